arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 64, data width of every channel in bits.
REQ-002 Parameter NUM_IN, default 4, number of input channels; legal range 2..16.
REQ-003 Derived SEL_W = $clog2(NUM_IN); not overridable.
REQ-004 clk  input  1  the single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  NUM_IN  per-channel valid.
REQ-007 in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_last  input  NUM_IN  per-channel end-of-burst marker.
REQ-009 in_ready  output  NUM_IN  per-channel accept; at most one bit high per cycle.
REQ-010 out_valid  output  1  output register holds a beat.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_sel  output  SEL_W  index of the channel that supplied out_data.
REQ-013 out_last  output  1  registered in_last of the supplied beat.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 load_en = !out_valid || out_ready; the block accepts a new beat only when load_en is 1.
REQ-016 grant = first i with in_valid[i]=1, searching from rr_ptr upward modulo NUM_IN; no grant when in_valid is all zero.
REQ-017 in_ready[grant] = load_en; all other in_ready bits 0; in_ready is combinational from in_valid, rr_ptr, out_valid, out_ready and lock state.
REQ-018 Transfer on input i = in_valid[i] && in_ready[i]; next cycle out_valid=1, out_data=in_data[i], out_sel=i, out_last=in_last[i] (latency exactly 1 cycle).
REQ-019 out_ready=1 with no input transfer in the same cycle: out_valid clears next cycle; out_data, out_sel and out_last hold their values.
REQ-020 out_ready=1 with an input transfer in the same cycle: register is replaced with no bubble; sustained throughput is 1 beat/cycle.
REQ-021 out_valid=1 with out_ready=0: out_data, out_sel and out_last stable; all in_ready bits 0.
REQ-022 After each transfer from channel g, rr_ptr = (g+1) mod NUM_IN; g=NUM_IN-1 wraps rr_ptr to 0.
REQ-023 No transfer: rr_ptr unchanged.
REQ-024 Withdrawn in_valid before transfer is legal; grant is recomputed the same cycle.

Reset
REQ-025 rst_n low: out_valid=0, out_data=0, out_sel=0, out_last=0, rr_ptr=0, lock cleared, immediately and independent of clk.
REQ-026 Reset mid-burst or with out_valid=1 discards the held beat; no transfer occurs while rst_n is low.
REQ-027 First grant after reset release starts the search at channel 0.

Configuration
REQ-028 Macro ARB_MUX_BURST_LOCK_EN defined: a transfer with in_last=0 sets lock to that channel; while locked, grant is forced to the locked channel (even if its in_valid is 0) and rr_ptr does not advance; a transfer with in_last=1 clears lock and advances rr_ptr per REQ-022.
REQ-029 Macro absent: no lock state; arbitration per beat per REQ-016/022; in_last only propagates to out_last; port list is identical in both builds.

Structure
REQ-030 Shared package arb_mux_pkg holds DEFAULT_WIDTH=64, MAX_NUM_IN=16 and function rr_next(ptr, n).
REQ-031 Round-robin search and rr_ptr/lock state live in a sub-module rr_arbiter (ports: clk, rst_n, req, advance, last, grant, grant_valid); arb_mux instantiates it once and owns the output register.

Verification
REQ-032 NUM_IN=4, all in_valid=1 continuously, out_ready=1, in_last=1 -> out_sel sequence 0,1,2,3,0, one beat per cycle.
REQ-033 in_valid=4'b1000 only, rr_ptr=0 -> grant 3; next accepted beat from channel 0 or 1 confirms rr_ptr wrapped to 0.
REQ-034 out_ready=0 for 5 cycles with data 64'hDEAD_BEEF_0000_0001 held -> out_data stable, in_ready=0 throughout; out_ready=1 -> out_valid drops next cycle if no input is valid.
REQ-035 rst_n pulsed low mid-stream, between clock edges -> out_valid=0 immediately; after release, first grant with all valid is channel 0.
REQ-036 ARB_MUX_BURST_LOCK_EN defined: channel 1 sends 3 beats with in_last=0,0,1 while channels 0 and 2 are valid -> out_sel=1,1,1, then 2.
REQ-037 Same stimulus with the macro absent -> out_sel interleaves 1,2,0,1 and out_last follows each beat.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arb_mux round-robin multiplexer.
// Optional feature macro used by the design: ARB_MUX_BURST_LOCK_EN.
package arb_mux_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int MAX_NUM_IN    = 16;
  localparam int MAX_SEL_W     = $clog2(MAX_NUM_IN);

  // Next round-robin pointer after serving channel ptr out of n channels.
  function automatic logic [MAX_SEL_W-1:0] rr_next(
    input logic [MAX_SEL_W-1:0] ptr,
    input logic [MAX_SEL_W:0]   n
  );
    logic [MAX_SEL_W:0] inc;
    inc = {1'b0, ptr} + {{MAX_SEL_W{1'b0}}, 1'b1};
    return (inc >= n) ? '0 : inc[MAX_SEL_W-1:0];
  endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Round-robin arbiter holding the search pointer and, when
// ARB_MUX_BURST_LOCK_EN is defined, the burst lock.
//
// lock state | meaning
// -----------+---------------------------------------------------------
// unlocked   | grant = first requester at or above rr_ptr (mod NUM_IN)
// locked     | grant forced to lock_ch until a beat with last=1 moves
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] req,
  input  logic              advance,
  input  logic              last,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_valid
);

  localparam logic [MAX_SEL_W:0] N_CH = (MAX_SEL_W + 1)'(NUM_IN);

  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] search_grant;
  logic             search_hit;
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] ptr_after_grant;

`ifdef ARB_MUX_BURST_LOCK_EN
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
`else
  logic unused_last;
  assign unused_last = last;
`endif

  function automatic int wrap_add(input int base, input int k);
    int s;
    s = base + k;
    return (s >= NUM_IN) ? s - NUM_IN : s;
  endfunction

  assign ptr_after_grant = SEL_W'(rr_next(MAX_SEL_W'(grant), N_CH));

  // Search upward from rr_ptr for the first requesting channel.
  always_comb begin
    search_grant = '0;
    search_hit   = 1'b0;
    cand         = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = SEL_W'(wrap_add(int'(rr_ptr_q), k));
      if (!search_hit && req[cand]) begin
        search_hit   = 1'b1;
        search_grant = cand;
      end
    end
  end

  // State register: pointer and lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
`ifdef ARB_MUX_BURST_LOCK_EN
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
`endif
    end else begin
      rr_ptr_q  <= rr_ptr_d;
`ifdef ARB_MUX_BURST_LOCK_EN
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
`endif
    end
  end

  // Next state: advance the pointer on a served beat, hold it inside a burst.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
`ifdef ARB_MUX_BURST_LOCK_EN
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (advance) begin
      if (!last) begin
        lock_d    = 1'b1;
        lock_ch_d = grant;
      end else begin
        lock_d   = 1'b0;
        rr_ptr_d = ptr_after_grant;
      end
    end
`else
    if (advance) rr_ptr_d = ptr_after_grant;
`endif
  end

  // Outputs: a held lock overrides the search result, even with req low.
  always_comb begin
    grant       = search_grant;
    grant_valid = search_hit;
`ifdef ARB_MUX_BURST_LOCK_EN
    if (lock_q) begin
      grant       = lock_ch_q;
      grant_valid = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/arb_mux.sv
// Round-robin N:1 multiplexer with a single registered output stage.
// Define ARB_MUX_BURST_LOCK_EN to keep a channel granted until in_last.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter  int WIDTH  = DEFAULT_WIDTH,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_last,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_last,
  input  logic                    out_ready
);

  logic             load_en;
  logic             transfer;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;

  assign load_en  = !out_valid || out_ready;
  // Reset gates the handshake so nothing is accepted while rst_n is low.
  assign transfer = rst_n && grant_valid && load_en && in_valid[grant];

  rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (in_valid),
    .advance     (transfer),
    .last        (in_last[grant]),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Only the granted channel may see ready, and only when the register can load.
  always_comb begin
    in_ready = '0;
    if (rst_n && grant_valid && load_en) in_ready[grant] = 1'b1;
  end

  // Output register: load on transfer, drain on out_ready, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
      out_sel   <= grant;
      out_last  <= in_last[grant];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux (NUM_IN=4, WIDTH=64) with a reference model.
// Honours ARB_MUX_BURST_LOCK_EN in the model and in the burst expectations.
module tb_arb_mux;

  localparam int W = 64;
  localparam int N = 4;
`ifdef ARB_MUX_BURST_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_last;
  logic           out_ready;

  arb_mux #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_ptr   = 0;
  int          m_lock  = -1;
  bit          m_valid = 0;
  logic [63:0] m_data  = '0;
  int          m_sel   = 0;
  bit          m_last  = 0;
  int          m_cnt[N];

  function automatic int mgrant();
    if (m_lock >= 0) return m_lock;
    for (int k = 0; k < N; k++)
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(negedge rst_n) begin
    m_ptr = 0; m_lock = -1; m_valid = 0; m_data = '0; m_sel = 0; m_last = 0;
  end

  always @(posedge clk) begin
    int g;
    bit xfer;
    if (rst_n === 1'b1) begin
      g    = mgrant();
      xfer = (g >= 0) && (!m_valid || out_ready) && in_valid[g];
      if (xfer) begin
        m_valid = 1;
        m_data  = in_data[g*W +: W];
        m_sel   = g;
        m_last  = in_last[g];
        m_cnt[g]++;
        if (LOCK_EN && !in_last[g]) m_lock = g;
        else begin
          m_lock = -1;
          m_ptr  = (g + 1) % N;
        end
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  // ---------------- per-cycle compare and beat log ----------------
  int q_sel[$];
  int q_last[$];

  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_rdy;
    exp_rdy = '0;
    if (rst_n === 1'b1) begin
      g = mgrant();
      if (g >= 0 && (!m_valid || out_ready)) exp_rdy[g] = 1'b1;
    end
    chk("in_ready",  64'(in_ready),  64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_data",  out_data,       m_data);
    chk("out_sel",   64'(out_sel),   64'(m_sel));
    chk("out_last",  64'(out_last),  64'(m_last));
    if (rst_n === 1'b1 && out_valid && out_ready) begin
      q_sel.push_back(int'(out_sel));
      q_last.push_back(int'(out_last));
    end
  end

  // ---------------- stimulus ----------------
  int seq        = 0;
  bit freeze     = 0;
  bit burst_mode = 0;
  int burst_base = 0;

  task automatic fill();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = {8'(i), 24'h0, 32'(seq)};
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      seq++;
      if (!freeze) fill();
      if (burst_mode) in_last[1] = ((m_cnt[1] - burst_base) == 2);
    end
  endtask

  task automatic clear_log();
    q_sel.delete();
    q_last.delete();
  endtask

  int exp_rr[5]     = '{0, 1, 2, 3, 0};
  int exp_bs_lock[4] = '{1, 1, 1, 2};
  int exp_bl_lock[4] = '{0, 0, 1, 1};
  int exp_bs_rr[4]   = '{1, 2, 0, 1};
  int exp_bl_rr[4]   = '{0, 1, 1, 0};

  initial begin
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    rst_n     = 1'b0;
    in_valid  = '0;
    in_last   = '1;
    out_ready = 1'b1;
    fill();
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  out_data,       64'd0);
    chk("rst_out_sel",   64'(out_sel),   64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    tick(2);
    rst_n = 1'b1;

    // All channels valid: strict rotation 0,1,2,3,0 at one beat per cycle.
    clear_log();
    in_valid = 4'b1111;
    tick(5);
    in_valid = '0;
    tick(2);
    chk("rr_count", 64'(q_sel.size()), 64'd5);
    for (int i = 0; i < 5 && i < q_sel.size(); i++) chk("rr_seq", 64'(q_sel[i]), 64'(exp_rr[i]));

    // Only channel 3 with rr_ptr at 0, then channels 0/1: pointer must wrap.
    @(posedge clk); #3 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    clear_log();
    in_valid = 4'b1000;
    #1 chk("wrap_ready", 64'(in_ready), 64'b1000);
    tick(1);
    in_valid = 4'b0011;
    tick(1);
    in_valid = '0;
    tick(2);
    chk("wrap_count", 64'(q_sel.size()), 64'd2);
    if (q_sel.size() == 2) begin
      chk("wrap_first",  64'(q_sel[0]), 64'd3);
      chk("wrap_second", 64'(q_sel[1]), 64'd0);
    end

    // Backpressure: held beat stays put and nothing is accepted.
    freeze    = 1;
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    in_data[2*W +: W] = 64'hDEAD_BEEF_0000_0001;
    tick(1);
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", 64'(in_ready),  64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data",  out_data,       64'hDEAD_BEEF_0000_0001);
      chk("bp_sel",   64'(out_sel),   64'd2);
      tick(1);
    end
    in_valid  = '0;
    out_ready = 1'b1;
    #1 chk("drain_ready", 64'(in_ready), 64'd0);
    tick(1);
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_data",  out_data,       64'hDEAD_BEEF_0000_0001);
    chk("drain_sel",   64'(out_sel),   64'd2);
    freeze = 0;

    // Asynchronous reset mid-stream, then first grant restarts at channel 0.
    in_valid = 4'b1111;
    tick(2);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_data",  out_data,       64'd0);
    chk("arst_ready", 64'(in_ready),  64'd0);
    tick(2);
    rst_n = 1'b1;
    clear_log();
    tick(1);
    in_valid = '0;
    tick(2);
    chk("arst_count", 64'(q_sel.size()), 64'd1);
    if (q_sel.size() >= 1) chk("arst_first", 64'(q_sel[0]), 64'd0);

    // Burst on channel 1 (last=0,0,1) while channels 0 and 2 stay valid.
    clear_log();
    in_valid = 4'b0001;
    in_last  = 4'b1111;
    tick(1);
    burst_mode = 1;
    burst_base = m_cnt[1];
    in_last    = 4'b1101;
    in_valid   = 4'b0111;
    tick(4);
    in_valid   = '0;
    burst_mode = 0;
    in_last    = '1;
    tick(2);
    chk("burst_count", 64'(q_sel.size()), 64'd5);
    if (q_sel.size() == 5) begin
      chk("burst_prime", 64'(q_sel[0]), 64'd0);
      for (int i = 0; i < 4; i++) begin
        if (LOCK_EN) begin
          chk("burst_sel",  64'(q_sel[i+1]),  64'(exp_bs_lock[i]));
          chk("burst_last", 64'(q_last[i+1]), 64'(exp_bl_lock[i]));
        end else begin
          chk("burst_sel",  64'(q_sel[i+1]),  64'(exp_bs_rr[i]));
          chk("burst_last", 64'(q_last[i+1]), 64'(exp_bl_rr[i]));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
